// File: rtl/versat_seq_pkg.sv
// Shared definitions for the Versat run sequencer: FSM states, CPU register
// map and CTRL/STATUS bit positions.
package versat_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_RD,
        S_LD_WR,
        S_RUN,
        S_GUARD,
        S_WAIT,
        S_ST_RD,
        S_ST_WR,
        S_FIN
    } seq_state_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_SRC    = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_LD_ACC = 3'd4;
    localparam logic [2:0] REG_ST_ACC = 3'd5;
    localparam logic [2:0] REG_LD_LEN = 3'd6;
    localparam logic [2:0] REG_ST_LEN = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int STAT_DONE  = 0;
    localparam int STAT_BUSY  = 1;

endpackage

// File: rtl/versat_seq_regs.sv
// CPU register slave: one-cycle registered handshake, transfer descriptor
// registers, start pulse and the sticky done flag that drives irq.
module versat_seq_regs
    import versat_seq_pkg::*;
#(
    parameter int SYS_ADDR_W = 32,
    parameter int DATA_W     = 32,
    parameter int ACC_ADDR_W = 12,
    parameter int LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid_i,
    input  logic [4:0]            s_addr_i,
    input  logic [DATA_W/8-1:0]   s_wstrb_i,
    input  logic [DATA_W-1:0]     s_wdata_i,
    output logic                  s_ready_o,
    output logic [DATA_W-1:0]     s_rdata_o,
    input  logic                  busy_i,
    input  logic                  fin_i,
    output logic                  start_o,
    output logic                  done_o,
    output logic [SYS_ADDR_W-1:0] src_o,
    output logic [SYS_ADDR_W-1:0] dst_o,
    output logic [ACC_ADDR_W-1:0] ld_acc_o,
    output logic [ACC_ADDR_W-1:0] st_acc_o,
    output logic [LEN_W-1:0]      ld_len_o,
    output logic [LEN_W-1:0]      st_len_o
);

    logic [2:0]            sel;
    logic                  accept, wr, ctrl_wr;
    logic                  unused_byte_sel;
    logic [DATA_W-1:0]     rdata_d;
    logic                  s_ready_q, start_q, done_q;
    logic [DATA_W-1:0]     s_rdata_q;
    logic [SYS_ADDR_W-1:0] src_q, dst_q;
    logic [ACC_ADDR_W-1:0] ld_acc_q, st_acc_q;
    logic [LEN_W-1:0]      ld_len_q, st_len_q;

    assign sel             = s_addr_i[4:2];
    assign unused_byte_sel = ^s_addr_i[1:0];
    // A request held across its own ready pulse is not accepted twice.
    assign accept          = s_valid_i && !s_ready_q;
    assign wr              = accept && (|s_wstrb_i);
    assign ctrl_wr         = wr && (sel == REG_CTRL);

    always_comb begin
        rdata_d = '0;
        case (sel)
            REG_STATUS: begin
                rdata_d[STAT_BUSY] = busy_i;
                rdata_d[STAT_DONE] = done_q;
            end
            REG_SRC:    rdata_d[SYS_ADDR_W-1:0] = src_q;
            REG_DST:    rdata_d[SYS_ADDR_W-1:0] = dst_q;
            REG_LD_ACC: rdata_d[ACC_ADDR_W-1:0] = ld_acc_q;
            REG_ST_ACC: rdata_d[ACC_ADDR_W-1:0] = st_acc_q;
            REG_LD_LEN: rdata_d[LEN_W-1:0]      = ld_len_q;
            REG_ST_LEN: rdata_d[LEN_W-1:0]      = st_len_q;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready_q <= 1'b0;
            s_rdata_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            ld_acc_q  <= '0;
            st_acc_q  <= '0;
            ld_len_q  <= '0;
            st_len_q  <= '0;
        end else begin
            s_ready_q <= accept;
            s_rdata_q <= (accept && !(|s_wstrb_i)) ? rdata_d : '0;
            start_q   <= ctrl_wr && s_wdata_i[CTRL_START];
            // Clear lands on the write edge, start one cycle later.
            if (fin_i)
                done_q <= 1'b1;
            else if (ctrl_wr && s_wdata_i[CTRL_CLEAR])
                done_q <= 1'b0;
            // Descriptors are frozen while busy, so they double as the start snapshot.
            if (wr && !busy_i && !start_q) begin
                case (sel)
                    REG_SRC:    src_q    <= s_wdata_i[SYS_ADDR_W-1:0];
                    REG_DST:    dst_q    <= s_wdata_i[SYS_ADDR_W-1:0];
                    REG_LD_ACC: ld_acc_q <= s_wdata_i[ACC_ADDR_W-1:0];
                    REG_ST_ACC: st_acc_q <= s_wdata_i[ACC_ADDR_W-1:0];
                    REG_LD_LEN: ld_len_q <= s_wdata_i[LEN_W-1:0];
                    REG_ST_LEN: st_len_q <= s_wdata_i[LEN_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign s_ready_o = s_ready_q;
    assign s_rdata_o = s_rdata_q;
    assign start_o   = start_q;
    assign done_o    = done_q;
    assign src_o     = src_q;
    assign dst_o     = dst_q;
    assign ld_acc_o  = ld_acc_q;
    assign st_acc_o  = st_acc_q;
    assign ld_len_o  = ld_len_q;
    assign st_len_o  = st_len_q;

endmodule

// File: rtl/versat_run_sequencer.sv
// Versat feed sequencer: load words into the accelerator, pulse run, wait for
// done, store results back to system memory, then flag completion.
module versat_run_sequencer
    import versat_seq_pkg::*;
#(
    parameter int SYS_ADDR_W = 32,
    parameter int DATA_W     = 32,
    parameter int ACC_ADDR_W = 12,
    parameter int LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [4:0]            s_addr,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic [DATA_W-1:0]     s_wdata,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic                  m_valid,
    output logic [SYS_ADDR_W-1:0] m_addr,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  acc_valid,
    output logic [ACC_ADDR_W-1:0] acc_addr,
    output logic [DATA_W/8-1:0]   acc_wstrb,
    output logic [DATA_W-1:0]     acc_wdata,
    input  logic                  acc_ready,
    input  logic [DATA_W-1:0]     acc_rdata,
    output logic                  run,
    input  logic                  done,
    output logic                  irq
);

    seq_state_e            state_q;
    logic                  start, busy, fin;
    logic [SYS_ADDR_W-1:0] src, dst;
    logic [ACC_ADDR_W-1:0] ld_acc, st_acc;
    logic [LEN_W-1:0]      ld_len, st_len;
    logic [LEN_W-1:0]      i_q, j_q, i_nxt, j_nxt;
    logic [DATA_W-1:0]     data_q;
    logic                  m_valid_q, acc_valid_q, run_q;
    logic [SYS_ADDR_W-1:0] m_addr_q;
    logic [ACC_ADDR_W-1:0] acc_addr_q;
    logic [DATA_W/8-1:0]   m_wstrb_q, acc_wstrb_q;

    assign busy  = (state_q != S_IDLE);
    assign fin   = (state_q == S_FIN);
    assign i_nxt = i_q + 1'b1;
    assign j_nxt = j_q + 1'b1;

    versat_seq_regs #(
        .SYS_ADDR_W(SYS_ADDR_W), .DATA_W(DATA_W), .ACC_ADDR_W(ACC_ADDR_W), .LEN_W(LEN_W)
    ) u_regs (
        .clk(clk), .rst(rst),
        .s_valid_i(s_valid), .s_addr_i(s_addr), .s_wstrb_i(s_wstrb), .s_wdata_i(s_wdata),
        .s_ready_o(s_ready), .s_rdata_o(s_rdata),
        .busy_i(busy), .fin_i(fin), .start_o(start), .done_o(irq),
        .src_o(src), .dst_o(dst), .ld_acc_o(ld_acc), .st_acc_o(st_acc),
        .ld_len_o(ld_len), .st_len_o(st_len)
    );

    // Master outputs are loaded on the transition into each state, so valid
    // and its payload stay put until the matching ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            data_q      <= '0;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wstrb_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_addr_q  <= '0;
            acc_wstrb_q <= '0;
            run_q       <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    i_q <= '0;
                    j_q <= '0;
                    if (ld_len != '0) begin
                        state_q   <= S_LD_RD;
                        m_valid_q <= 1'b1;
                        m_wstrb_q <= '0;
                        m_addr_q  <= src;
                    end else begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end
                end
                S_LD_RD: if (m_ready) begin
                    data_q      <= m_rdata;
                    m_valid_q   <= 1'b0;
                    acc_valid_q <= 1'b1;
                    acc_wstrb_q <= '1;
                    acc_addr_q  <= ld_acc + ACC_ADDR_W'(i_q);
                    state_q     <= S_LD_WR;
                end
                S_LD_WR: if (acc_ready) begin
                    acc_valid_q <= 1'b0;
                    i_q         <= i_nxt;
                    if (i_nxt == ld_len) begin
                        state_q <= S_RUN;
                        run_q   <= 1'b1;
                    end else begin
                        state_q   <= S_LD_RD;
                        m_valid_q <= 1'b1;
                        m_addr_q  <= src + SYS_ADDR_W'({i_nxt, 2'b00});
                    end
                end
                S_RUN:   state_q <= S_GUARD;
                // A stale done level from the previous job is skipped here.
                S_GUARD: state_q <= S_WAIT;
                S_WAIT: if (done) begin
                    if (st_len != '0) begin
                        state_q     <= S_ST_RD;
                        acc_valid_q <= 1'b1;
                        acc_wstrb_q <= '0;
                        acc_addr_q  <= st_acc;
                    end else begin
                        state_q <= S_FIN;
                    end
                end
                S_ST_RD: if (acc_ready) begin
                    data_q      <= acc_rdata;
                    acc_valid_q <= 1'b0;
                    m_valid_q   <= 1'b1;
                    m_wstrb_q   <= '1;
                    m_addr_q    <= dst + SYS_ADDR_W'({j_q, 2'b00});
                    state_q     <= S_ST_WR;
                end
                S_ST_WR: if (m_ready) begin
                    m_valid_q <= 1'b0;
                    j_q       <= j_nxt;
                    if (j_nxt == st_len) begin
                        state_q <= S_FIN;
                    end else begin
                        state_q     <= S_ST_RD;
                        acc_valid_q <= 1'b1;
                        acc_addr_q  <= st_acc + ACC_ADDR_W'(j_nxt);
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_wstrb   = m_wstrb_q;
    assign m_wdata   = data_q;
    assign acc_valid = acc_valid_q;
    assign acc_addr  = acc_addr_q;
    assign acc_wstrb = acc_wstrb_q;
    assign acc_wdata = data_q;
    assign run       = run_q;

endmodule

// File: tb/tb_versat_run_sequencer.sv
// Randomized bench for versat_run_sequencer: memory/accelerator responders with
// random stalls, a transaction-level reference model and protocol checks.
module tb_versat_run_sequencer;
    import versat_seq_pkg::*;

    typedef logic [64:0] txn_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        s_valid, s_ready, m_valid, m_ready, acc_valid, acc_ready, run, done, irq;
    logic [4:0]  s_addr;
    logic [3:0]  s_wstrb, m_wstrb, acc_wstrb;
    logic [31:0] s_wdata, s_rdata, m_addr, m_wdata, m_rdata, acc_wdata, acc_rdata;
    logic [11:0] acc_addr;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, run_cnt = 0, run_cyc = 0, st_first = -1;
    int stall_max = 0, acc_delay = 0;

    logic [31:0] sys_mem [logic [31:0]];
    logic [31:0] acc_mem [logic [11:0]];
    logic [31:0] model_sys [logic [31:0]];
    logic [31:0] model_acc [logic [11:0]];
    txn_t sys_log[$], acc_log[$];

    always #5 clk = ~clk;

    versat_run_sequencer dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wstrb(acc_wstrb), .acc_wdata(acc_wdata),
        .acc_ready(acc_ready), .acc_rdata(acc_rdata),
        .run(run), .done(done), .irq(irq)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sys_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction
    function automatic logic [31:0] acc_init(input logic [11:0] a);
        return {a, ~a, 8'h3C};
    endfunction
    function automatic logic [31:0] sys_get(input logic [31:0] a);
        return sys_mem.exists(a) ? sys_mem[a] : sys_init(a);
    endfunction
    function automatic logic [31:0] acc_get(input logic [11:0] a);
        return acc_mem.exists(a) ? acc_mem[a] : acc_init(a);
    endfunction
    function automatic logic [31:0] msys(input logic [31:0] a);
        return model_sys.exists(a) ? model_sys[a] : sys_init(a);
    endfunction
    function automatic logic [31:0] macc(input logic [11:0] a);
        return model_acc.exists(a) ? model_acc[a] : acc_init(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Run pulse counter and cycle of the first store-phase accelerator read after it.
    always @(negedge clk) begin
        if (run) begin
            run_cnt  <= run_cnt + 1;
            run_cyc  <= cyc;
            st_first <= -1;
        end else if (acc_valid && acc_wstrb == 4'h0 && st_first < 0) begin
            st_first <= cyc;
        end
    end

    // Accelerator: done idles high; after run it drops for acc_delay cycles.
    initial begin
        done = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && run && acc_delay > 0) begin
                done = 1'b0;
                repeat (acc_delay) @(negedge clk);
                done = 1'b1;
            end
        end
    end

    logic [31:0] ma, md;
    logic [3:0]  mw;
    int          mn;
    initial begin
        m_ready = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            if (rst && m_valid) begin
                ma = m_addr; mw = m_wstrb; md = m_wdata; mn = int'($urandom_range(0, stall_max));
                repeat (mn) begin
                    @(negedge clk);
                    if (rst) chk("m_hold", 72'({m_valid, m_wstrb, m_addr, m_wdata}), 72'({1'b1, mw, ma, md}));
                end
                if (rst) begin
                    m_ready = 1'b1;
                    if (mw != 4'h0) begin
                        sys_mem[ma] = md;
                        sys_log.push_back({1'b1, ma, md});
                    end else begin
                        m_rdata = sys_get(ma);
                        sys_log.push_back({1'b0, ma, 32'h0});
                    end
                end
            end
        end
    end

    logic [11:0] aa;
    logic [31:0] ad;
    logic [3:0]  aw;
    int          an;
    initial begin
        acc_ready = 1'b0; acc_rdata = '0;
        forever begin
            @(negedge clk);
            acc_ready = 1'b0;
            if (rst && acc_valid) begin
                aa = acc_addr; aw = acc_wstrb; ad = acc_wdata; an = int'($urandom_range(0, stall_max));
                repeat (an) begin
                    @(negedge clk);
                    if (rst) chk("acc_hold", 72'({acc_valid, acc_wstrb, acc_addr, acc_wdata}), 72'({1'b1, aw, aa, ad}));
                end
                if (rst) begin
                    acc_ready = 1'b1;
                    if (aw != 4'h0) begin
                        acc_mem[aa] = ad;
                        acc_log.push_back({1'b1, 20'h0, aa, ad});
                    end else begin
                        acc_rdata = acc_get(aa);
                        acc_log.push_back({1'b0, 20'h0, aa, 32'h0});
                    end
                end
            end
        end
    end

    task automatic cpu_xfer(input logic [2:0] r, input logic [3:0] strb, input logic [31:0] wd,
                            output logic [31:0] rd);
        int k;
        @(negedge clk);
        s_valid = 1'b1; s_addr = {r, 2'($urandom)}; s_wstrb = strb; s_wdata = wd;
        for (k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (s_ready) break;
        end
        chk("s_ready_lat", 72'({s_ready, 8'(k)}), 72'({1'b1, 8'd0}));
        rd = s_rdata;
        s_valid = 1'b0; s_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("s_ready_pulse", 72'(s_ready), 72'(0));
    endtask

    task automatic cpu_wr(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        cpu_xfer(r, 4'hF, d, dummy);
    endtask

    task automatic cpu_rd(input logic [2:0] r, output logic [31:0] d);
        cpu_xfer(r, 4'h0, 32'h0, d);
    endtask

    task automatic run_op(input logic [31:0] src, input logic [31:0] dst, input logic [11:0] lda,
                          input logic [11:0] sta, input int ldl, input int stl, input int dly,
                          input int stall, input bit poke);
        txn_t        es[$], ea[$];
        int          sb, ab, r0, k;
        logic [31:0] rd, a, v;
        logic [11:0] x;
        acc_delay = dly; stall_max = stall;
        cpu_wr(REG_SRC, src);    cpu_wr(REG_DST, dst);
        cpu_wr(REG_LD_ACC, 32'(lda)); cpu_wr(REG_ST_ACC, 32'(sta));
        cpu_wr(REG_LD_LEN, 32'(ldl)); cpu_wr(REG_ST_LEN, 32'(stl));
        // Reference: every load word lands at LD_ACC+k, every result at DST+4j.
        for (int i = 0; i < ldl; i++) begin
            a = src + 32'(4 * i); x = lda + 12'(i); v = msys(a);
            es.push_back({1'b0, a, 32'h0});
            ea.push_back({1'b1, 20'h0, x, v});
            model_acc[x] = v;
        end
        for (int j = 0; j < stl; j++) begin
            a = dst + 32'(4 * j); x = sta + 12'(j); v = macc(x);
            ea.push_back({1'b0, 20'h0, x, 32'h0});
            es.push_back({1'b1, a, v});
            model_sys[a] = v;
        end
        sb = sys_log.size(); ab = acc_log.size(); r0 = run_cnt;
        cpu_wr(REG_CTRL, 32'h1);
        if (poke) begin
            cpu_rd(REG_STATUS, rd);
            chk("busy_status", 72'(rd), 72'(2));
            cpu_wr(REG_CTRL, 32'h1);
            cpu_wr(REG_LD_LEN, 32'd7);
        end
        for (k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            if (irq) break;
        end
        chk("irq_set", 72'(irq), 72'(1));
        chk("sys_count", 72'(sys_log.size() - sb), 72'(es.size()));
        for (int i = 0; i < es.size() && sb + i < sys_log.size(); i++)
            chk("sys_txn", 72'(sys_log[sb + i]), 72'(es[i]));
        chk("acc_count", 72'(acc_log.size() - ab), 72'(ea.size()));
        for (int i = 0; i < ea.size() && ab + i < acc_log.size(); i++)
            chk("acc_txn", 72'(acc_log[ab + i]), 72'(ea[i]));
        chk("run_pulses", 72'(run_cnt - r0), 72'(1));
        if (stl != 0)
            chk("store_gap", 72'(st_first - run_cyc), 72'((dly + 1 > 3) ? dly + 1 : 3));
        cpu_rd(REG_STATUS, rd);
        chk("done_status", 72'(rd), 72'(1));
        if (poke) begin
            cpu_rd(REG_LD_LEN, rd);
            chk("ld_len_kept", 72'(rd), 72'(ldl));
        end
        cpu_wr(REG_CTRL, 32'h2);
        cpu_rd(REG_STATUS, rd);
        chk("clr_status", 72'(rd), 72'(0));
        chk("irq_clr", 72'(irq), 72'(0));
    endtask

    initial begin
        logic [31:0] rd;
        int k;
        s_valid = 1'b0; s_addr = '0; s_wstrb = '0; s_wdata = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 72'({m_valid, acc_valid, run, irq, s_ready}), 72'(0));
        chk("rst_bus", 72'({m_addr, acc_addr, m_wstrb, acc_wstrb}), 72'(0));
        chk("rst_data", 72'({m_wdata, s_rdata}), 72'(0));
        rst = 1'b1;
        cpu_rd(REG_STATUS, rd);
        chk("status_init", 72'(rd), 72'(0));

        run_op(32'h100, 32'h0, 12'h400, 12'h0, 4, 0, 5, 0, 1'b0);
        run_op(32'h0, 32'h200, 12'h0, 12'h800, 0, 3, 10, 0, 1'b0);
        run_op(32'h40, 32'h80, 12'h20, 12'h20, 2, 2, 0, 2, 1'b0);
        run_op(32'h1000, 32'h2000, 12'h100, 12'h104, 3, 3, 30, 3, 1'b1);
        run_op(32'hFFFF_FFF8, 32'hFFFF_FFFC, 12'hFFE, 12'hFFF, 4, 3, 1, 5, 1'b0);
        for (int t = 0; t < 8; t++)
            run_op($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 12'($urandom), 12'($urandom),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 5)), 1'b0);

        // Abort mid load: outputs must collapse without waiting for a clock edge.
        acc_delay = 0; stall_max = 3;
        cpu_wr(REG_SRC, 32'h3000); cpu_wr(REG_LD_ACC, 32'h10);
        cpu_wr(REG_LD_LEN, 32'd5); cpu_wr(REG_ST_LEN, 32'd0);
        cpu_wr(REG_CTRL, 32'h1);
        for (k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (acc_valid && acc_wstrb != 4'h0) break;
        end
        chk("ld_wr_seen", 72'(acc_valid), 72'(1));
        rst = 1'b0;
        #1;
        chk("rst_async", 72'({acc_valid, m_valid, run, irq}), 72'(0));
        @(negedge clk); rst = 1'b1;
        cpu_rd(REG_STATUS, rd);
        chk("status_after_rst", 72'(rd), 72'(0));
        cpu_rd(REG_LD_LEN, rd);
        chk("ld_len_after_rst", 72'(rd), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
